// File: rtl/nn_pkg.sv
// Shared fixed-point constants for the neural-network datapath blocks.
package nn_pkg;

    // Default widths: Q4.4 data, 20-bit accumulator, 8-bit neuron memory address.
    localparam int unsigned NN_DATA_W = 8;
    localparam int unsigned NN_FRAC_W = 4;
    localparam int unsigned NN_ACC_W  = 20;
    localparam int unsigned NN_ADDR_W = 8;

    // Full-precision product of two data words.
    localparam int unsigned NN_PROD_W = 2 * NN_DATA_W;

    // Signed range limits for the default data and accumulator widths.
    localparam logic signed [NN_DATA_W-1:0] NN_DATA_MAX = {1'b0, {(NN_DATA_W-1){1'b1}}};
    localparam logic signed [NN_DATA_W-1:0] NN_DATA_MIN = {1'b1, {(NN_DATA_W-1){1'b0}}};
    localparam logic signed [NN_ACC_W-1:0]  NN_ACC_MAX  = {1'b0, {(NN_ACC_W-1){1'b1}}};
    localparam logic signed [NN_ACC_W-1:0]  NN_ACC_MIN  = {1'b1, {(NN_ACC_W-1){1'b0}}};

endpackage

// File: rtl/neuron_activation.sv
// Combinational fixed-point activation: rescale by FRAC_W (floor), ReLU, saturate to the
// positive output range. sat_o flags an upper clamp only; ReLU zeroing is not saturation.
module neuron_activation #(
    parameter int unsigned IN_W   = 20,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned FRAC_W = 4
) (
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] y_o,
    output logic             sat_o
);

    localparam int                   OutMaxInt = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [IN_W-1:0] OutMax  = IN_W'(OutMaxInt);

    logic signed [IN_W-1:0] shifted;

    assign shifted = $signed(x_i) >>> FRAC_W;

    // Clamp the rescaled value into [0, OutMax].
    always_comb begin
        sat_o = 1'b0;
        y_o   = shifted[OUT_W-1:0];
        if (shifted < 0) begin
            y_o = '0;
        end else if (shifted > OutMax) begin
            y_o   = OutMax[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_unit.sv
// Per-neuron multiply-accumulate stage behind the layer address generator. Aligns the
// generator's flags with the RAM read data, multiplies, accumulates one dot product per
// neuron and writes the activated result back to neuron memory.
module neuron_mac_unit
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned FRAC_W = NN_FRAC_W,
    parameter int unsigned ACC_W  = NN_ACC_W,
    parameter int unsigned ADDR_W = NN_ADDR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_layer_done,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0] neuro_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              layer_done,
    output logic              busy,
    output logic              sat_flag
);

    localparam int unsigned PW = 2 * DATA_W;

    logic              clear;

    // Stage D: flags delayed to match RAM read latency; entry RD_LAT-1 is aligned.
    logic [RD_LAT-1:0] d_valid_q, d_last_q, d_done_q;
    logic [ADDR_W-1:0] d_waddr_q [RD_LAT];

    // Stage M: registered product with its flags.
    logic              m_valid_q, m_last_q, m_done_q;
    logic [ADDR_W-1:0] m_waddr_q;
    logic [PW-1:0]     m_prod_q;
    logic [PW-1:0]     prod_d;

    // Stage A: accumulator and output registers.
    logic [ACC_W-1:0]  acc_q;
    logic              first_q;
    logic              wr_en_q, layer_done_q, sat_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [ACC_W:0]    base_wide, prod_wide, sum_wide;
    logic [ACC_W-1:0]  sum_sat;
    logic              sum_clamp;
    logic [DATA_W-1:0] act_data;
    logic              act_sat;

    assign clear  = reset | start;
    assign prod_d = PW'($signed(weight_data)) * PW'($signed(neuro_data));

    // Alignment shift register; flags are qualified by in_valid at the input.
    always_ff @(posedge clk) begin
        if (clear) begin
            d_valid_q <= '0;
            d_last_q  <= '0;
            d_done_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) d_waddr_q[i] <= '0;
        end else begin
            d_valid_q[0] <= in_valid;
            d_last_q[0]  <= in_valid & in_last;
            d_done_q[0]  <= in_valid & in_layer_done;
            d_waddr_q[0] <= in_waddr;
            for (int i = 1; i < RD_LAT; i++) begin
                d_valid_q[i] <= d_valid_q[i-1];
                d_last_q[i]  <= d_last_q[i-1];
                d_done_q[i]  <= d_done_q[i-1];
                d_waddr_q[i] <= d_waddr_q[i-1];
            end
        end
    end

    // Multiply stage: capture the exact product on an aligned valid term.
    always_ff @(posedge clk) begin
        if (clear) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_done_q  <= 1'b0;
            m_waddr_q <= '0;
            m_prod_q  <= '0;
        end else begin
            m_valid_q <= d_valid_q[RD_LAT-1];
            m_last_q  <= d_last_q[RD_LAT-1];
            m_done_q  <= d_done_q[RD_LAT-1];
            if (d_valid_q[RD_LAT-1]) begin
                m_waddr_q <= d_waddr_q[RD_LAT-1];
                m_prod_q  <= prod_d;
            end
        end
    end

    // Saturating add in one extra bit; overflow shows as the top two bits differing.
    always_comb begin
        base_wide = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
        prod_wide = {{(ACC_W + 1 - PW){m_prod_q[PW-1]}}, m_prod_q};
        sum_wide  = base_wide + prod_wide;
        sum_clamp = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        sum_sat   = sum_wide[ACC_W-1:0];
        if (sum_clamp) begin
            sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    neuron_activation #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .FRAC_W(FRAC_W)
    ) u_act (
        .x_i  (sum_sat),
        .y_o  (act_data),
        .sat_o(act_sat)
    );

    // Accumulate non-last terms; on the last term emit the write and restart the sum.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc_q        <= '0;
            first_q      <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            layer_done_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            layer_done_q <= 1'b0;
            if (m_valid_q) begin
                if (m_last_q) begin
                    acc_q        <= '0;
                    first_q      <= 1'b1;
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= m_waddr_q;
                    wr_data_q    <= act_data;
                    layer_done_q <= m_done_q;
                    sat_q        <= sat_q | sum_clamp | act_sat;
                end else begin
                    acc_q   <= sum_sat;
                    first_q <= 1'b0;
                    sat_q   <= sat_q | sum_clamp;
                end
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign layer_done = layer_done_q;
    assign sat_flag   = sat_q;
    assign busy       = (|d_valid_q) | m_valid_q | ~first_q;

endmodule
